// File: rtl/i2c_cfg_pkg.sv
// Shared I2C configuration definitions.
// Arbiter states, word width and slave addresses.
package i2c_cfg_pkg;

  localparam int I2C_W = 24;

  localparam logic [7:0] CODEC_ADDR = 8'h34;
  localparam logic [7:0] VIDEO_ADDR = 8'h40;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RELEASE,
    ST_FINISH
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cntW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2c_req_arbiter_sync_2ff.sv
// Two-flop synchronizer for one asynchronous level.
// Clears to 0 on reset.
module sync_2ff (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic iD,
  output logic oQ
);

  logic meta;

  // Double-register the asynchronous input into iCLK.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      meta <= 1'b0;
      oQ   <= 1'b0;
    end else begin
      meta <= iD;
      oQ   <= meta;
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Two-port arbiter in front of the I2C transfer engine.
// Round-robin grant, NACK retry, timeout, per-port done/err.
module i2c_req_arbiter
  import i2c_cfg_pkg::*;
#(
  parameter int RETRY_MAX   = 3,
  parameter int TIMEOUT_CYC = 4_000_000
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iREQ0,
  input  logic             iREQ1,
  input  logic [I2C_W-1:0] iDATA0,
  input  logic [I2C_W-1:0] iDATA1,
  output logic             oDONE0,
  output logic             oDONE1,
  output logic             oERR0,
  output logic             oERR1,
  output logic             oBUSY,
  output logic             oI2C_GO,
  output logic [I2C_W-1:0] oI2C_DATA,
  input  logic             iI2C_END,
  input  logic             iI2C_ACK
);

  localparam int TW = cntW(TIMEOUT_CYC);
  localparam int RW = cntW(RETRY_MAX + 1);

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] RTY_LAST = RW'(RETRY_MAX);

  state_t stateQ;
  state_t stateD;

  logic             endS;
  logic             ackS;
  logic             endDly;
  logic             endRise;

  logic             ptrQ;
  logic             ownerQ;
  logic [RW-1:0]    retryQ;
  logic [TW-1:0]    tmoQ;
  logic             relaunchQ;
  logic             errQ;
  logic [I2C_W-1:0] dataQ;

  logic             grant;
  logic             grantPort;
  logic             tmoHit;
  logic             relaunchGo;
  logic             finEntry;

  sync_2ff uEndSync (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .iD    (iI2C_END),
    .oQ    (endS)
  );

  sync_2ff uAckSync (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .iD    (iI2C_ACK),
    .oQ    (ackS)
  );

  assign endRise    = endS & ~endDly;
  assign tmoHit     = (tmoQ == TMO_LAST);
  assign relaunchGo = (stateQ == ST_RELEASE) & ~endS & relaunchQ;
  assign finEntry   = (stateD == ST_FINISH) & (stateQ != ST_FINISH);

  // Next state plus grant decision; END rise beats a same-cycle timeout.
  always_comb begin
    stateD    = stateQ;
    grant     = 1'b0;
    grantPort = 1'b0;
    unique case (stateQ)
      ST_IDLE: begin
        if (iREQ0 | iREQ1) begin
          grant     = 1'b1;
          grantPort = (iREQ0 & iREQ1) ? ptrQ : iREQ1;
          stateD    = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (endRise) begin
          stateD = ST_RELEASE;
        end else if (tmoHit) begin
          stateD = ST_FINISH;
        end
      end
      ST_RELEASE: begin
        if (!endS) begin
          stateD = relaunchQ ? ST_LAUNCH : ST_FINISH;
        end
      end
      ST_FINISH: begin
        stateD = ST_IDLE;
      end
      default: begin
        stateD = ST_IDLE;
      end
    endcase
  end

  // State register and END edge history.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      stateQ <= ST_IDLE;
      endDly <= 1'b0;
    end else begin
      stateQ <= stateD;
      endDly <= endS;
    end
  end

  // Pointer moves away from the port just served.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      ptrQ <= 1'b0;
    end else if (finEntry) begin
      ptrQ <= ~ownerQ;
    end
  end

  // Latch word and owner at grant; held until the next grant.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      dataQ  <= '0;
      ownerQ <= 1'b0;
    end else if (grant) begin
      dataQ  <= grantPort ? iDATA1 : iDATA0;
      ownerQ <= grantPort;
    end
  end

  // Timeout counter: cleared per launch, saturates at its limit.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      tmoQ <= '0;
    end else if (grant || relaunchGo) begin
      tmoQ <= '0;
    end else if (stateQ == ST_LAUNCH && !tmoHit) begin
      tmoQ <= tmoQ + 1'b1;
    end
  end

  // Attempt outcome: retry count, relaunch request and error flag.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      retryQ    <= '0;
      relaunchQ <= 1'b0;
      errQ      <= 1'b0;
    end else if (grant) begin
      retryQ    <= '0;
      relaunchQ <= 1'b0;
      errQ      <= 1'b0;
    end else if (stateQ == ST_LAUNCH) begin
      if (endRise) begin
        if (!ackS) begin
          relaunchQ <= 1'b0;
          errQ      <= 1'b0;
        end else if (retryQ != RTY_LAST) begin
          retryQ    <= retryQ + 1'b1;
          relaunchQ <= 1'b1;
        end else begin
          relaunchQ <= 1'b0;
          errQ      <= 1'b1;
        end
      end else if (tmoHit) begin
        errQ <= 1'b1;
      end
    end else if (relaunchGo) begin
      relaunchQ <= 1'b0;
    end
  end

  assign oI2C_GO   = (stateQ == ST_LAUNCH);
  assign oBUSY     = (stateQ != ST_IDLE);
  assign oI2C_DATA = dataQ;
  assign oDONE0    = (stateQ == ST_FINISH) & ~ownerQ;
  assign oDONE1    = (stateQ == ST_FINISH) &  ownerQ;
  assign oERR0     = oDONE0 & errQ;
  assign oERR1     = oDONE1 & errQ;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: random requests, scoreboard checks.
// Controller model reacts to the low bits of the data word.
module tb_i2c_req_arbiter;
  import i2c_cfg_pkg::*;

  localparam int RMAX = 3;
  localparam int TMO  = 100;

  logic             iCLK = 1'b0;
  logic             iRST_N = 1'b0;
  logic             iREQ0 = 1'b0;
  logic             iREQ1 = 1'b0;
  logic [I2C_W-1:0] iDATA0 = '0;
  logic [I2C_W-1:0] iDATA1 = '0;
  logic             oDONE0, oDONE1, oERR0, oERR1, oBUSY, oI2C_GO;
  logic [I2C_W-1:0] oI2C_DATA;
  logic             iI2C_END = 1'b0;
  logic             iI2C_ACK = 1'b0;

  i2c_req_arbiter #(.RETRY_MAX(RMAX), .TIMEOUT_CYC(TMO)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .iREQ0(iREQ0), .iREQ1(iREQ1),
    .iDATA0(iDATA0), .iDATA1(iDATA1),
    .oDONE0(oDONE0), .oDONE1(oDONE1),
    .oERR0(oERR0), .oERR1(oERR1),
    .oBUSY(oBUSY), .oI2C_GO(oI2C_GO),
    .oI2C_DATA(oI2C_DATA),
    .iI2C_END(iI2C_END), .iI2C_ACK(iI2C_ACK)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    bit          port;
    logic [23:0] data;
    int          go;
    bit          err;
    bit          hang;
  } exp_t;

  exp_t q[$];
  int   vecs = 0;
  int   miss = 0;
  bit   mptr = 1'b0;
  int   attempt = 0;

  task automatic chk(string nm, int act, int exp);
    vecs++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic failNote(string nm);
    vecs++;
    miss++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // Slave behaviour coded in data[2:0]: 0..4 = NACK count, 7 = hang.
  function automatic int nackOf(logic [23:0] d);
    return (d[2:0] <= 3'd4) ? int'(d[2:0]) : 0;
  endfunction

  function automatic bit hangOf(logic [23:0] d);
    return d[2:0] == 3'd7;
  endfunction

  // Reference: outcome of one transfer from the slave behaviour.
  task automatic push(bit port, logic [23:0] d);
    exp_t e;
    int n;
    n = nackOf(d);
    e.port = port;
    e.data = d;
    e.hang = hangOf(d);
    if (e.hang) begin
      e.go  = 1;
      e.err = 1'b1;
    end else if (n > RMAX) begin
      e.go  = RMAX + 1;
      e.err = 1'b1;
    end else begin
      e.go  = n + 1;
      e.err = 1'b0;
    end
    q.push_back(e);
    mptr = ~port;
  endtask

  task automatic issue(bit r0, bit r1, logic [23:0] d0, logic [23:0] d1);
    bit f;
    @(negedge iCLK);
    if (r0 && r1) begin
      f = mptr;
      push(f, f ? d1 : d0);
      push(~f, f ? d0 : d1);
    end else if (r0) begin
      push(1'b0, d0);
    end else if (r1) begin
      push(1'b1, d1);
    end
    iDATA0 = d0;
    iDATA1 = d1;
    iREQ0  = r0;
    iREQ1  = r1;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((q.size() != 0 || oBUSY || iREQ0 || iREQ1) && n < 3000) begin
      @(negedge iCLK);
      n++;
    end
    if (n >= 3000) begin
      failNote("idleTimeout");
      q.delete();
      iREQ0 = 1'b0;
      iREQ1 = 1'b0;
    end
    repeat (2) @(negedge iCLK);
  endtask

  task automatic waitGo();
    int n;
    n = 0;
    while (!oI2C_GO && n < 200) begin
      @(negedge iCLK);
      n++;
    end
    if (!oI2C_GO) failNote("goTimeout");
  endtask

  function automatic logic [23:0] rndWord();
    logic [7:0] a;
    a = ($urandom_range(0, 1) != 0) ? CODEC_ADDR : VIDEO_ADDR;
    return {a, 8'($urandom), 8'($urandom)};
  endfunction

  // Controller model: END/ACK driven off-edge, as from another clock.
  initial begin
    logic [23:0] d;
    forever begin
      @(posedge oI2C_GO);
      #1 d = oI2C_DATA;
      if (hangOf(d)) begin
        wait (!oI2C_GO);
      end else begin
        repeat ($urandom_range(1, 5)) @(posedge iCLK);
        #2 iI2C_ACK = (attempt < nackOf(d));
        @(posedge iCLK);
        #3 iI2C_END = 1'b1;
        wait (!oI2C_GO);
        repeat ($urandom_range(0, 4)) @(posedge iCLK);
        #2 iI2C_END = 1'b0;
        iI2C_ACK = 1'b0;
        attempt++;
      end
    end
  end

  // Requesters drop their request once their done pulse is seen.
  initial begin
    forever begin
      @(negedge iCLK);
      if (oDONE0) iREQ0 = 1'b0;
      if (oDONE1) iREQ1 = 1'b0;
      if (oDONE0 || oDONE1) attempt = 0;
    end
  end

  // Monitor: GO pulse accounting and done/err scoreboard.
  initial begin
    int goCnt, hiCnt;
    bit prevGo, prevDone;
    exp_t e;
    goCnt = 0;
    hiCnt = 0;
    prevGo = 1'b0;
    prevDone = 1'b0;
    forever begin
      @(negedge iCLK);
      if (!iRST_N) begin
        goCnt = 0;
        hiCnt = 0;
        prevGo = 1'b0;
        prevDone = 1'b0;
      end else begin
        if (oI2C_GO && !prevGo) begin
          goCnt++;
          hiCnt = 0;
          if (q.size() == 0) failNote("goWithoutRequest");
          else chk("dataAtGo", int'(oI2C_DATA), int'(q[0].data));
        end
        if (oI2C_GO) hiCnt++;
        if (oDONE0 || oDONE1) begin
          chk("singleDone", int'(oDONE0 & oDONE1), 0);
          chk("donePulseWidth", int'(prevDone), 0);
          if (q.size() == 0) begin
            failNote("unexpectedDone");
          end else begin
            e = q.pop_front();
            chk("donePort", int'(oDONE1), int'(e.port));
            chk("errFlag", int'(oDONE1 ? oERR1 : oERR0), int'(e.err));
            chk("errOther", int'(oDONE1 ? oERR0 : oERR1), 0);
            chk("goPulses", goCnt, e.go);
            chk("finishPath", int'(prevGo), int'(e.hang));
            chk("busyAtDone", int'(oBUSY), 1);
            if (e.hang) chk("timeoutCycles", hiCnt, TMO);
          end
          goCnt = 0;
        end
        prevGo = oI2C_GO;
        prevDone = oDONE0 | oDONE1;
      end
    end
  end

  initial begin
    bit r0, r1;
    logic [23:0] d0, d1;
    int sel;

    repeat (3) @(negedge iCLK);
    chk("rstGo", int'(oI2C_GO), 0);
    chk("rstBusy", int'(oBUSY), 0);
    chk("rstDone0", int'(oDONE0), 0);
    chk("rstDone1", int'(oDONE1), 0);
    chk("rstErr0", int'(oERR0), 0);
    chk("rstErr1", int'(oERR1), 0);
    chk("rstData", int'(oI2C_DATA), 0);
    iRST_N = 1'b1;
    repeat (2) @(negedge iCLK);

    issue(1'b1, 1'b0, 24'h340C00, 24'h0);
    waitIdle();
    chk("dataHeld", int'(oI2C_DATA), int'(24'h340C00));

    issue(1'b1, 1'b1, 24'h341201, 24'h34047A);
    waitIdle();
    issue(1'b1, 1'b1, 24'h341201, 24'h34047A);
    waitIdle();

    issue(1'b0, 1'b1, 24'h0, 24'h401104);
    waitIdle();
    issue(1'b0, 1'b1, 24'h0, 24'h401101);
    waitIdle();

    issue(1'b1, 1'b0, 24'h340007, 24'h0);
    waitIdle();

    issue(1'b1, 1'b0, 24'h340500, 24'h0);
    waitIdle();
    issue(1'b0, 1'b1, 24'h0, 24'h400017);
    waitGo();
    repeat (5) @(negedge iCLK);
    #2 iRST_N = 1'b0;
    #1;
    chk("asyncGoDrop", int'(oI2C_GO), 0);
    chk("asyncBusyDrop", int'(oBUSY), 0);
    iREQ1 = 1'b0;
    q.delete();
    mptr = 1'b0;
    attempt = 0;
    repeat (2) @(negedge iCLK);
    iRST_N = 1'b1;
    @(negedge iCLK);
    issue(1'b1, 1'b1, 24'h342200, 24'h403300);
    waitIdle();

    issue(1'b0, 1'b1, 24'h0, 24'h400A02);
    waitGo();
    repeat (3) @(negedge iCLK);
    iREQ1 = 1'b0;
    waitIdle();

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 2);
      r0 = (sel != 1);
      r1 = (sel != 0);
      d0 = rndWord();
      d1 = rndWord();
      issue(r0, r1, d0, d1);
      waitIdle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
